peaks_frame_mailbox: RTL
========================

Name: peaks_frame_mailbox

Overview:
- Double-buffered mailbox between the peak finder and the host driver read/write bus.
- Captures each peak-finder result frame (time counter, PEAKS frequencies, PEAKS amplitudes) into a bank the host is not reading.
- Publishes that bank to the host as a coherent, locked frame. The host releases the frame by writing an acknowledge; this replaces the ad-hoc "don't update while address < 33" guard.

Parameters:
- PEAKS, 6, number of peaks per frame
- FREQ_WIDTH, 8, width of each peak frequency
- AMPL_WIDTH, 16, width of each peak amplitude (byte-aligned, ≥16; only the top 16 bits are exported)
- TIME_WIDTH, 32, width of the peak-finder time counter

Ports:
- clk  in  1  system clock (50 MHz domain)
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  single-cycle pulse: peak-finder outputs are valid this cycle
- counter_in  in  TIME_WIDTH  frame time counter
- freqs_in  in  PEAKS*FREQ_WIDTH  packed; peak k at [k*FREQ_WIDTH +: FREQ_WIDTH]
- ampls_in  in  PEAKS*AMPL_WIDTH  packed; peak k at [k*AMPL_WIDTH +: AMPL_WIDTH]
- chipselect  in  1  host bus select
- write  in  1  host write strobe (qualified by chipselect)
- address  in  8  host byte address
- writedata  in  8  host write data
- readdata  out  8  registered host read data
- irq  out  1  level-high while a published frame is unacknowledged

Behaviour:
Clocking and reset
- One clock (clk). reset is synchronous and active-high.
- On reset: state=EMPTY, bank select pub_sel=0, seq=0, dropped=0, readdata=0, irq=0. Bank contents are don't-care but must read 0 when EMPTY.
- Reset asserted mid-frame discards all frames.

State machine
- EMPTY: no frame is published.
  - valid_in → capture into bank ~pub_sel, then flip pub_sel, seq+1, go to PUB. The frame is visible on the cycle after valid_in.
- PUB: host owns bank pub_sel.
  - valid_in → capture into bank ~pub_sel, go to PEND.
  - ack → go to EMPTY.
  - valid_in and ack in the same cycle → the capture is published immediately (flip pub_sel, seq+1); stay in PUB.
- PEND: bank ~pub_sel holds a newer frame.
  - valid_in → overwrite the pending bank; dropped+1 (saturates at 255).
  - ack → flip pub_sel, seq+1, go to PUB.
  - valid_in and ack in the same cycle → flip pub_sel, seq+1, capture into the freed bank, stay in PEND; no drop.
- ack = chipselect & write & address==8'h80 & writedata[0]. An ack in EMPTY is ignored.
- writedata[1] in the same write clears dropped. A clear has priority over a simultaneous increment.
- Writes to any other address are ignored.
- irq = (state != EMPTY), registered.

Capture
- Single cycle. All fields are latched from the valid_in cycle.
- The published bank never changes while in PUB or PEND.

Read map (bank pub_sel; all frame bytes read 0 in EMPTY)
- 0..3: counter_in, MSB first (byte 0 = [TIME_WIDTH-1 -: 8]).
- 4..4+PEAKS-1: freq k.
- 10+4k, 11+4k: amplitude k [AMPL_WIDTH-1 -: 8], then [AMPL_WIDTH-9 -: 8].
- 12+4k, 13+4k: read 0.
- 34..127, 0x83..0xF7: read 0.
- 0x80 status: bit0 = frame_ready (state != EMPTY), bit1 = pending (state == PEND), bit2 = dropped != 0, bits7:3 = 0.
- 0x81: dropped.
- 0x82: seq (8-bit, wraps 255→0).
- 0xF8..0xFF: fixed bytes 42, 53, 84, 71, 7, 25, 48, 96.

Read timing
- readdata updates on the clock after a cycle with chipselect & !write (1-cycle latency). Otherwise it holds.
- A read in the same cycle as an ack returns the pre-ack bank and status.

Test Plan:
- Reset, then valid_in with counter=0x01020304, freq0=0x11, ampl0=0xABCD → next cycle irq=1. Reads return addr0=0x01, addr3=0x04, addr4=0x11, addr10=0xAB, addr11=0xCD, addr12=0x00, 0x82=1, 0x80=0x01.
- Publish frame A; valid_in frame B; read addr0 → still A, 0x80=0x03. Write 0x80←0x01 → addr0=B, seq=2, 0x80=0x01. Ack again → irq=0, addr0=0.
- In PEND, three more valid_in pulses (C, D, E) → 0x81=3, 0x80=0x07. Ack → frame E published. Write 0x80←0x02 → 0x81=0, irq stays 1.
- In PEND, valid_in coincident with ack → old pending frame published; new frame pending; 0x81 unchanged; state PEND.
- 300 drops → 0x81=255. 256 publishes → 0x82 wraps to 0. Read 0xF8..0xFF → 42, 53, 84, 71, 7, 25, 48, 96. Read 0x40 → 0.
- Reset asserted while in PEND → irq=0, 0x80=0, 0x82=0, 0x81=0, addr0=0.

Source files
------------

// File: rtl/peaks_frame_mailbox.sv
// Double-buffered mailbox between the peak finder and the host bus.
// Frames are published whole and stay locked until the host acknowledges them.
module peaks_frame_mailbox #(
    parameter int PEAKS      = 6,
    parameter int FREQ_WIDTH = 8,
    parameter int AMPL_WIDTH = 16,
    parameter int TIME_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic [TIME_WIDTH-1:0]       counter_in,
    input  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in,
    input  logic [PEAKS*AMPL_WIDTH-1:0] ampls_in,
    input  logic                        chipselect,
    input  logic                        write,
    input  logic [7:0]                  address,
    input  logic [7:0]                  writedata,
    output logic [7:0]                  readdata,
    output logic                        irq
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PUB   = 2'd1,
        PEND  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic pub_sel;
    logic flip, cap, cap_bank, drop_inc;
    logic ack, clr;
    logic [7:0] seq, dropped, rd_byte;
    logic unused_wdata;

    logic [TIME_WIDTH-1:0] cnt_bank  [2];
    logic [FREQ_WIDTH-1:0] freq_bank [2][PEAKS];
    logic [15:0]           ampl_bank [2][PEAKS];
    logic [TIME_WIDTH-1:0] cnt_word;

    assign ack = chipselect & write & (address == 8'h80) & writedata[0];
    assign clr = chipselect & write & (address == 8'h80) & writedata[1];
    assign unused_wdata = ^writedata[7:2];

    always_comb begin
        state_nx = state;
        flip     = 1'b0;
        cap      = 1'b0;
        cap_bank = ~pub_sel;
        drop_inc = 1'b0;
        unique case (state)
            EMPTY: begin
                if (valid_in) begin
                    cap      = 1'b1;
                    flip     = 1'b1;
                    state_nx = PUB;
                end
            end
            PUB: begin
                if (valid_in) begin
                    cap = 1'b1;
                    if (ack) flip = 1'b1;
                    else     state_nx = PEND;
                end else if (ack) begin
                    state_nx = EMPTY;
                end
            end
            PEND: begin
                if (valid_in && ack) begin
                    // pending frame goes live; the freed bank takes the new one
                    cap      = 1'b1;
                    flip     = 1'b1;
                    cap_bank = pub_sel;
                end else if (valid_in) begin
                    cap      = 1'b1;
                    drop_inc = 1'b1;
                end else if (ack) begin
                    flip     = 1'b1;
                    state_nx = PUB;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            pub_sel <= 1'b0;
            seq     <= 8'd0;
            dropped <= 8'd0;
            irq     <= 1'b0;
        end else begin
            state <= state_nx;
            irq   <= (state_nx != EMPTY);
            if (flip) begin
                pub_sel <= ~pub_sel;
                seq     <= seq + 8'd1;
            end
            if (clr)
                dropped <= 8'd0;
            else if (drop_inc && dropped != 8'hFF)
                dropped <= dropped + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            cnt_bank[cap_bank] <= counter_in;
            for (int k = 0; k < PEAKS; k++) begin
                freq_bank[cap_bank][k] <= freqs_in[k*FREQ_WIDTH +: FREQ_WIDTH];
                ampl_bank[cap_bank][k] <= ampls_in[k*AMPL_WIDTH + AMPL_WIDTH-16 +: 16];
            end
        end
    end

    assign cnt_word = cnt_bank[pub_sel];

    always_comb begin
        rd_byte = 8'd0;
        if (state != EMPTY) begin
            if (address < 8'd4) begin
                unique case (address[1:0])
                    2'd0: rd_byte = cnt_word[TIME_WIDTH-1  -: 8];
                    2'd1: rd_byte = cnt_word[TIME_WIDTH-9  -: 8];
                    2'd2: rd_byte = cnt_word[TIME_WIDTH-17 -: 8];
                    default: rd_byte = cnt_word[TIME_WIDTH-25 -: 8];
                endcase
            end
            for (int k = 0; k < PEAKS; k++) begin
                if (address == 8'(4 + k))
                    rd_byte = 8'(freq_bank[pub_sel][k]);
                if (address == 8'(10 + 4*k))
                    rd_byte = ampl_bank[pub_sel][k][15:8];
                if (address == 8'(11 + 4*k))
                    rd_byte = ampl_bank[pub_sel][k][7:0];
            end
        end
        if (address == 8'h80)
            rd_byte = {5'd0, dropped != 8'd0, state == PEND, state != EMPTY};
        if (address == 8'h81)
            rd_byte = dropped;
        if (address == 8'h82)
            rd_byte = seq;
        if (address[7:3] == 5'h1F) begin
            unique case (address[2:0])
                3'd0: rd_byte = 8'd42;
                3'd1: rd_byte = 8'd53;
                3'd2: rd_byte = 8'd84;
                3'd3: rd_byte = 8'd71;
                3'd4: rd_byte = 8'd7;
                3'd5: rd_byte = 8'd25;
                3'd6: rd_byte = 8'd48;
                default: rd_byte = 8'd96;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= 8'd0;
        else if (chipselect && !write)
            readdata <= rd_byte;
    end

endmodule
